ma_mem_interface: RTL and testbench
===================================

MA_MEM_INTERFACE -- requirements
Module: ma_mem_interface

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent in REQ waiting for mem_ack before aborting.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have pipeline-side inputs mem_write (1), mem_read (1), func_3 (3), ALU_out (32, byte address), DATA_2 (32, store data), all from the EX/MA pipeline register.
REQ-005 SHALL have output busywait, 1, a pipeline stall request that freezes all pipeline registers while high.
REQ-006 SHALL have output load_data, 32, registered, the aligned and extended load result.
REQ-007 SHALL have output access_fault, 1, a one-cycle pulse on misaligned access, on mem_read and mem_write both high, or on timeout.
REQ-008 SHALL have memory-side outputs mem_req (1), mem_we (1), mem_addr (32, word aligned, bits[1:0]=0), mem_wdata (32), mem_be (4).
REQ-009 SHALL have memory-side inputs mem_rdata (32) and mem_ack (1), a one-cycle completion pulse.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-011 In IDLE with a legal access (exactly one of mem_read/mem_write high, aligned), the block SHALL assert busywait combinationally in the same cycle, latch address, data, func_3 and direction, and enter REQ at the next edge.
REQ-012 Alignment SHALL be checked as: halfword (func_3[1:0]=01) requires addr[0]=0; word (10) requires addr[1:0]=00; byte accesses are always aligned.
REQ-013 In IDLE with an illegal access, the block SHALL pulse access_fault for that cycle, keep busywait low, stay in IDLE, issue no mem_req, and leave load_data unchanged.
REQ-014 In REQ, the block SHALL hold mem_req=1 and busywait=1, with mem_addr, mem_we, mem_wdata and mem_be stable from the latched values.
REQ-015 In REQ, when mem_ack=1, the block SHALL capture the aligned load value into load_data (loads only) and enter DONE; mem_req SHALL drop at that edge.
REQ-016 A timeout counter SHALL reset on entry to REQ and increment each REQ cycle; on reaching TIMEOUT_CYCLES without mem_ack, the block SHALL enter DONE with load_data=0 and access_fault pulsed during DONE.
REQ-017 DONE SHALL last exactly one cycle with busywait=0 so the pipeline advances, then return to IDLE unconditionally; inputs are not sampled in DONE.
REQ-018 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<(2*addr[1]); SW 1111. Loads SHALL drive mem_be=1111.
REQ-019 Store data SHALL be lane-replicated: SB {4{DATA_2[7:0]}}; SH {2{DATA_2[15:0]}}; SW DATA_2.
REQ-020 Loads SHALL select the byte or halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-021 func_3 values 011, 110 and 111 SHALL be treated as illegal (access_fault, no access).
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 Total latency of a load with an ack k cycles after the request SHALL be k+2 cycles of stall-visible behaviour: k+1 busywait cycles plus one DONE cycle.

Reset
REQ-024 While RESET=0, the block SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, access_fault=0, busywait=0, and counter=0.
REQ-025 Reset asserted during REQ SHALL abort the transaction with no DONE cycle; any later mem_ack SHALL be ignored.

Structure
REQ-026 A shared package ma_pkg SHALL hold the func_3 encodings (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101), the FSM state type, and the default TIMEOUT_CYCLES.
REQ-027 Load lane selection and extension SHALL be a combinational sub-module ma_load_align (inputs word, addr[1:0], func_3; output 32-bit result).

Verification
REQ-028 SW, addr 0x100, data 0xDEADBEEF, ack after 2 cycles -> mem_be=1111, mem_addr=0x100, busywait high 3 cycles, then DONE, with a single mem_req transaction.
REQ-029 LB, addr 0x103, mem_rdata=0x80FF_FF7F -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-030 SH, addr 0x102, data 0x0000_1234 -> mem_be=1100, mem_wdata=0x12341234; LH at addr 0x101 -> access_fault pulse, no mem_req.
REQ-031 Load with mem_ack never asserted -> mem_req dropped after 255 REQ cycles, then DONE with access_fault=1 and load_data=0.
REQ-032 RESET low mid-REQ, then mem_ack pulsed after release -> outputs zero immediately, FSM stays IDLE, load_data stays 0.
REQ-033 mem_read=mem_write=1 -> access_fault pulse, busywait=0; stray mem_ack in IDLE -> no state change.

Source files
------------

// File: rtl/ma_pkg.sv
// ma_pkg
//   Shared definitions for the memory-access stage interface:
//   func_3 encodings, FSM state type and constants, the default
//   timeout, and small legality helpers used by the top module.
package ma_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // func_3 encodings (loads and stores share the low codes)
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // FSM state type and encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Codes 011, 110 and 111 have no defined access.
  function automatic logic f3_legal(input logic [2:0] f3);
    return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  // Size comes from func_3[1:0]; bytes are always aligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ma_mem_interface_if.sv
// ma_mem_interface_if
//   Bundles the pipeline-side and memory-side signals of the MA stage.
//   Pipeline side: mem_read/mem_write/func_3/ALU_out/DATA_2 in,
//                  busywait/load_data/access_fault out.
//   Memory side:   mem_req/mem_we/mem_addr/mem_wdata/mem_be out,
//                  mem_rdata/mem_ack in.
//   Handshake: mem_req is held high (with stable address/data/enables)
//   until a single-cycle mem_ack completes the transfer; busywait is the
//   pipeline's not-ready, keeping mem_read/mem_write and operands frozen
//   while it is high.
//   slave  : view used by ma_mem_interface.
//   master : view used by whoever drives the pipeline and models memory.
interface ma_mem_interface_if;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  func_3;
  logic [31:0] ALU_out;
  logic [31:0] DATA_2;
  logic        busywait;
  logic [31:0] load_data;
  logic        access_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  mem_write, mem_read, func_3, ALU_out, DATA_2, mem_rdata, mem_ack,
    output busywait, load_data, access_fault,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output mem_write, mem_read, func_3, ALU_out, DATA_2, mem_rdata, mem_ack,
    input  busywait, load_data, access_fault,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/ma_load_align.sv
// ma_load_align
//   Combinational load lane selection and extension.
//   word_i   : raw 32-bit word from memory
//   addr_i   : byte offset within the word
//   func_3_i : load type
//   result_o : aligned, sign/zero-extended load value
module ma_load_align
  import ma_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  func_3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (func_3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result_o = {24'b0, byte_sel};
      F3_HU:   result_o = {16'b0, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/ma_mem_interface.sv
// ma_mem_interface
//   Memory-access stage bridge: turns a pipeline load/store into a single
//   request/acknowledge memory transaction, stalling the pipeline while
//   it is outstanding.
//   CLK         : clock, rising edge
//   RESET       : asynchronous active-low reset
//   bus         : pipeline and memory signals (slave view)
//   dbg_state_o : current FSM state
//   IDLE -> REQ on a legal access, REQ -> DONE on mem_ack or timeout,
//   DONE -> IDLE unconditionally after one cycle.
module ma_mem_interface
  import ma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  ma_mem_interface_if.slave   bus,
  output state_t              dbg_state_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   load_q, load_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic          access;
  logic          legal;
  logic          start;
  logic          idle_fault;
  logic [31:0]   aligned_load;

  ma_load_align u_align (
    .word_i   (bus.mem_rdata),
    .addr_i   (addr_q[1:0]),
    .func_3_i (f3_q),
    .result_o (aligned_load)
  );

  assign access     = bus.mem_read | bus.mem_write;
  assign legal      = (bus.mem_read ^ bus.mem_write) && f3_legal(bus.func_3)
                      && is_aligned(bus.func_3[1:0], bus.ALU_out[1:0]);
  assign start      = (state_q == ST_IDLE) && legal;
  assign idle_fault = (state_q == ST_IDLE) && access && !legal;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = bus.ALU_out;
          we_d    = bus.mem_write;
          f3_d    = bus.func_3;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = ST_REQ;
          // Lane-replicate store data so any enabled lane carries it.
          case (bus.func_3[1:0])
            2'b00: begin
              wdata_d = {4{bus.DATA_2[7:0]}};
              be_d    = 4'b0001 << bus.ALU_out[1:0];
            end
            2'b01: begin
              wdata_d = {2{bus.DATA_2[15:0]}};
              be_d    = 4'b0011 << {bus.ALU_out[1], 1'b0};
            end
            default: begin
              wdata_d = bus.DATA_2;
              be_d    = 4'b1111;
            end
          endcase
          if (!bus.mem_write) be_d = 4'b1111;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          if (!we_q) load_d = aligned_load;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          load_d  = '0;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Combinational stall/fault outputs are gated by RESET so they drop the
  // moment reset is asserted, even with a live request on the inputs.
  assign bus.busywait     = RESET && (start || (state_q == ST_REQ));
  assign bus.access_fault = RESET && (idle_fault || ((state_q == ST_DONE) && tmo_q));
  assign bus.mem_req      = (state_q == ST_REQ);
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_be       = be_q;
  assign bus.load_data    = load_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ma_mem_interface.sv
// tb_ma_mem_interface
//   Directed vector table, hand-written corner sequences (stray ack,
//   timeout, reset mid-request) and randomized accesses checked against
//   a behavioural model of the load/store rules.
module tb_ma_mem_interface;
  import ma_pkg::*;

  localparam int TMO = 255;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  ma_mem_interface_if bus();

  ma_mem_interface dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr);
    if (rd == wr) return 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic [7:0] m;
    if (!wr) return 4'hF;
    m = ((8'd1 << nbytes(f3)) - 8'd1) << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = data[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    logic [63:0] v;
    int n;
    n = nbytes(f3);
    v = {32'b0, word} >> (8 * int'(addr[1:0]));
    v = v & ((64'd1 << (8*n)) - 64'd1);
    if (!f3[2] && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.func_3    = 3'b000;
    bus.ALU_out   = '0;
    bus.DATA_2    = '0;
  endtask

  // ack_at: REQ cycle (1-based) in which mem_ack pulses; 0 means never.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int ack_at,
                           input logic exp_legal, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int   nreq;
    int   busy;
    logic acked;
    logic req_ok;
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.func_3    = f3;
    bus.ALU_out   = addr;
    bus.DATA_2    = data;
    bus.mem_ack   = 1'b0;
    #1;
    if (!exp_legal) begin
      chk("idle_fault", bus.access_fault, rd | wr);
      chk("idle_busy", bus.busywait, 0);
      chk("idle_req", bus.mem_req, 0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("fault_pulse", bus.access_fault, 0);
      chk("fault_req", bus.mem_req, 0);
      chk("fault_load", bus.load_data, exp_load);
      model_load = exp_load;
      return;
    end
    chk("start_busy", bus.busywait, 1);
    chk("start_fault", bus.access_fault, 0);
    exp_q.push_back(exp_load);
    busy   = 1;
    nreq   = 0;
    acked  = 1'b0;
    req_ok = 1'b1;
    while (!acked && nreq < TMO) begin
      @(negedge clk);
      nreq++;
      bus.mem_ack   = (nreq == ack_at);
      bus.mem_rdata = (nreq == ack_at) ? rdata : $urandom;
      #1;
      busy += int'(bus.busywait);
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== {addr[31:2], 2'b00} ||
          bus.mem_we !== wr || bus.mem_be !== exp_be ||
          (wr && bus.mem_wdata !== exp_wdata)) req_ok = 1'b0;
      if (nreq == 1) begin
        chk("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("req_we", bus.mem_we, wr);
        chk("req_be", bus.mem_be, exp_be);
        if (wr) chk("req_wdata", bus.mem_wdata, exp_wdata);
      end
      acked = (nreq == ack_at);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    idle_inputs();
    #1;
    chk("req_stable", req_ok, 1);
    chk("busy_cycles", busy, (ack_at == 0) ? TMO + 1 : ack_at + 1);
    chk("done_busy", bus.busywait, 0);
    chk("done_req", bus.mem_req, 0);
    chk("done_fault", bus.access_fault, ack_at == 0);
    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
    else chk("load_data", bus.load_data, exp_q.pop_front());
    @(negedge clk);
    #1;
    chk("post_fault", bus.access_fault, 0);
    chk("post_req", bus.mem_req, 0);
    model_load = exp_load;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ack_at;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        2, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 1, 1'b1, 4'hF, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 3, 1'b1, 4'hF, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1, 1'b1, 4'hC, 32'h12341234, 32'h00000080};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1'b0, 4'hF, 32'h0,        32'h00000080};
    vecs[5]  = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        1, 1'b0, 4'hF, 32'h0,        32'h00000080};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'hCAFEF00D, 1, 1'b1, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h87654321, 2, 1'b1, 4'hF, 32'h0,        32'h00008765};
    vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h87654321, 1, 1'b1, 4'hF, 32'h0,        32'hFFFF8765};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 1'b0, 4'hF, 32'h0,        32'hFFFF8765};
    vecs[10] = '{1'b1, 1'b0, 3'b110, 32'h000, 32'h0,        32'h0,        1, 1'b0, 4'hF, 32'h0,        32'hFFFF8765};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        4, 1'b1, 4'h2, 32'hABABABAB, 32'hFFFF8765};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1'b0, 4'hF, 32'h0,        32'hFFFF8765};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00007FFE, 1, 1'b1, 4'hF, 32'h0,        32'h00007FFE};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, data, rdata;
    int          kind;
    bit          lg;

    rst_n         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    idle_inputs();
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_load", bus.load_data, 0);
    chk("rst_fault", bus.access_fault, 0);
    chk("rst_busy", bus.busywait, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++)
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].data,
                vecs[i].rdata, vecs[i].ack_at, vecs[i].legal, vecs[i].be,
                vecs[i].wdata, vecs[i].load);

    // Stray ack while idle
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_req", bus.mem_req, 0);
    chk("stray_busy", bus.busywait, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("stray_load", bus.load_data, model_load);
    chk("stray_req2", bus.mem_req, 0);

    // Timeout: load never acknowledged
    do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 1'b1, 4'hF, 32'h0, 32'h0);

    // A load to leave a non-zero value before the reset test
    do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h5A5A0001, 1, 1'b1, 4'hF, 32'h0, 32'h5A5A0001);

    // Reset asserted in the middle of REQ
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.func_3   = 3'b010;
    bus.ALU_out  = 32'h500;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_be", bus.mem_be, 0);
    chk("mid_rst_load", bus.load_data, 0);
    chk("mid_rst_busy", bus.busywait, 0);
    chk("mid_rst_fault", bus.access_fault, 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    #1;
    chk("post_rst_req", bus.mem_req, 0);
    chk("post_rst_busy", bus.busywait, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("post_rst_load", bus.load_data, 0);
    chk("post_rst_fault", bus.access_fault, 0);
    model_load = '0;

    // Randomized accesses against the model
    for (int t = 0; t < 80; t++) begin
      kind  = $urandom_range(0, 9);
      rd    = (kind <= 4) || (kind == 8);
      wr    = (kind >= 5 && kind <= 8);
      f3    = (wr && !rd) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr  = $urandom;
      data  = $urandom;
      rdata = $urandom;
      lg    = m_legal(rd, wr, f3, addr);
      do_access(rd, wr, f3, addr, data, rdata, $urandom_range(1, 6), lg,
                m_be(wr, f3, addr), m_wdata(f3, data),
                (lg && rd) ? m_load(f3, addr, rdata) : model_load);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
